mips_data_bus_bridge: RTL

- Sits directly downstream of the Harvard CPU's data port.
- Converts the CPU's single-cycle data_read/data_write strobes into transactions on a pipelined memory bus with waitrequest and readdatavalid; one transaction outstanding at a time.
- Drives a stall output; the top level feeds its inverse to the CPU's clock_enable, freezing the CPU until the access completes.
- Also keeps a free-running stall-cycle counter for performance checks.

---
 rtl/mips_bus_pkg.sv | 15 +
 rtl/mips_bus_timeout_ctr.sv | 29 ++
 rtl/mips_data_bus_bridge.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS data bus bridge.
// Holds the bridge FSM state enum, abort read data and byte-enable pattern.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      DONE
   } t_bus_state;

   localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;
   localparam logic [3:0]  BYTEEN_ALL   = 4'hF;

endpackage

// File: rtl/mips_bus_timeout_ctr.sv
// Bus timeout counter: cleared at transaction start, counts while enabled.
// Ports: clk, reset_n, clear, enable in; done high at count TC-1 (saturates).
module mips_bus_timeout_ctr #(
   parameter int TC = 256
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam int W = (TC > 2) ? $clog2(TC) : 1;

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !done) begin
         cnt <= cnt + W'(1);
      end
   end

   assign done = (cnt == W'(TC - 1));

endmodule

// File: rtl/mips_data_bus_bridge.sv
// Bridges CPU single-cycle data strobes to a waitrequest/readdatavalid bus,
// one transaction at a time, stalling the CPU until the access completes.
// Ports: cpu_* (CPU side), mem_* (bus side), stall_count, bus_error.
// Optional bus timeout abort enabled by defining MIPS_BUS_TIMEOUT_EN.
module mips_data_bus_bridge
   import mips_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      cpu_address,
   input  logic             cpu_read,
   input  logic             cpu_write,
   input  logic [31:0]      cpu_writedata,
   output logic [31:0]      cpu_readdata,
   output logic             cpu_stall,
   output logic [31:0]      mem_address,
   output logic             mem_read,
   output logic             mem_write,
   output logic [31:0]      mem_writedata,
   output logic [3:0]       mem_byteenable,
   input  logic             mem_waitrequest,
   input  logic [31:0]      mem_readdata,
   input  logic             mem_readdatavalid,
   output logic [CNT_W-1:0] stall_count,
   output logic             bus_error
);

   t_bus_state state, state_nx;

   logic is_wr;
   logic start;
   logic accept;
   logic rvalid;
   logic abort;

   assign start  = (state == IDLE) && (cpu_read || cpu_write);
   assign accept = (state == REQ) && !mem_waitrequest;
   // Responses outside RESP are stale and ignored.
   assign rvalid = (state == RESP) && mem_readdatavalid;

`ifdef MIPS_BUS_TIMEOUT_EN
   logic tmo;

   mips_bus_timeout_ctr #(
      .TC(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (start),
      .enable ((state == REQ) || (state == RESP)),
      .done   (tmo)
   );

   // A normal completion in the terminal cycle takes precedence.
   assign abort = tmo && (((state == REQ) && !accept) ||
                          ((state == RESP) && !rvalid));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus_error <= 1'b0;
      end else if (abort) begin
         bus_error <= 1'b1;
      end
   end
`else
   logic unused_tmo;
   assign unused_tmo = TIMEOUT_CYCLES[0];
   assign abort      = 1'b0;
   assign bus_error  = 1'b0;
`endif

   logic unused_addr;
   assign unused_addr = ^cpu_address[1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = REQ;
         REQ: begin
            if (abort) state_nx = DONE;
            else if (accept) state_nx = is_wr ? DONE : RESP;
         end
         RESP: if (abort || rvalid) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Read wins when both strobes are high; the write is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         is_wr         <= 1'b0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
         cpu_readdata  <= '0;
      end else begin
         if (start) begin
            is_wr         <= !cpu_read;
            mem_read      <= cpu_read;
            mem_write     <= !cpu_read;
            mem_address   <= {cpu_address[31:2], 2'b00};
            mem_writedata <= cpu_writedata;
         end else if ((state == REQ) && (accept || abort)) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
         end
         if (rvalid) begin
            cpu_readdata <= mem_readdata;
         end else if (abort && !is_wr) begin
            cpu_readdata <= BUS_ERR_DATA;
         end
      end
   end

   assign cpu_stall      = start || (state == REQ) || (state == RESP);
   assign mem_byteenable = BYTEEN_ALL;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_count <= '0;
      end else if (cpu_stall) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule
